// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   WIDTH-bit universal shift register. It supports hold, load, shift left,
//   shift right, rotate left, rotate right, arithmetic shift right and clear.
//   A burst engine repeats one shift/rotate op for burst_len cycles and
//   reports its progress on busy and done.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   en         enables single-cycle ops while idle
//   mode       op select (see MODE_* below)
//   d          parallel load data
//   sin_r      serial in to bit 0 for shl
//   sin_l      serial in to MSB for shr
//   start      burst request for a shift/rotate mode
//   burst_len  number of burst steps
//   q, q_bar   register contents and its complement
//   sout_l     q[WIDTH-1]
//   sout_r     q[0]
//   busy       high while burst steps remain
//   done       one-cycle pulse after the final burst step
//
// state  | meaning
// IDLE   | single-cycle ops via en/mode; accepts a burst start
// BURST  | repeating the latched op until the step counter runs out
module univ_shift_reg #(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned     CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_start;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      MODE_HOLD:  res = cur;
      MODE_LOAD:  res = din;
      MODE_SHL:   res = {cur[WIDTH-2:0], sr};
      MODE_SHR:   res = {sl, cur[WIDTH-1:1]};
      MODE_ROL:   res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR:   res = {cur[0], cur[WIDTH-1:1]};
      MODE_ASR:   res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      MODE_CLEAR: res = '0;
      default:    res = cur;
    endcase
    return res;
  endfunction

  // Only the shift/rotate modes may be repeated; a zero length is ignored.
  assign valid_start = start && (mode >= MODE_SHL) && (mode <= MODE_ASR)
                       && (burst_len != '0);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    op_d    = op_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_BURST: begin
        // Serial inputs are sampled live on every step.
        q_d   = apply_op(op_q, q_q, d, sin_l, sin_r);
        rem_d = rem_q - CNT_ONE;
        if (rem_q == CNT_ONE) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy_d = 1'b0;
        if (valid_start) begin
          // The start edge already performs step 1.
          q_d   = apply_op(mode, q_q, d, sin_l, sin_r);
          op_d  = mode;
          rem_d = burst_len - CNT_ONE;
          if (burst_len == CNT_ONE) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_BURST;
          end
        end else if (en) begin
          q_d = apply_op(mode, q_q, d, sin_l, sin_r);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      q_q     <= RESET_VAL;
      op_q    <= MODE_HOLD;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q      = q_q;
  assign q_bar  = ~q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int unsigned      WIDTH     = 8;
  localparam logic [WIDTH-1:0] RESET_VAL = 8'hA5;
  localparam int unsigned      CNT_W     = 4;

  logic             clk;
  logic             reset_n;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  univ_shift_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin_r    (sin_r),
    .sin_l    (sin_l),
    .start    (start),
    .burst_len(burst_len),
    .q        (q),
    .q_bar    (q_bar),
    .sout_l   (sout_l),
    .sout_r   (sout_r),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
  } exp_t;

  typedef struct {
    string            name;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] exp_q;
  } vec_t;

  exp_t exp_fifo[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [2:0] m,
                       input logic [WIDTH-1:0] dv, input logic sl,
                       input logic sr, input logic st,
                       input logic [CNT_W-1:0] bl);
    en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
    start = st; burst_len = bl;
  endtask

  task automatic expect_next(input string name, input logic [WIDTH-1:0] eq,
                             input logic eb, input logic ed);
    exp_t e;
    e.name = name; e.q = eq; e.busy = eb; e.done = ed;
    exp_fifo.push_back(e);
  endtask

  // Advance one edge, then compare against the oldest queued expectation.
  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_fifo.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = exp_fifo.pop_front();
      check({e.name, ".q"},      q,       e.q);
      check({e.name, ".q_bar"},  q_bar,   ~e.q);
      check({e.name, ".sout_l"}, 8'(sout_l), 8'(e.q[WIDTH-1]));
      check({e.name, ".sout_r"}, 8'(sout_r), 8'(e.q[0]));
      check({e.name, ".busy"},   8'(busy), 8'(e.busy));
      check({e.name, ".done"},   8'(done), 8'(e.done));
    end
  endtask

  task automatic step(input string name, input logic [WIDTH-1:0] eq,
                      input logic eb, input logic ed);
    expect_next(name, eq, eb, ed);
    tick_check();
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{"load81",    1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81},
      '{"shl",       1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 8'h03},
      '{"load81b",   1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81},
      '{"shr",       1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 8'h40},
      '{"load81c",   1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81},
      '{"rol",       1'b1, 3'b100, 8'h00, 1'b1, 1'b0, 8'h03},
      '{"load81d",   1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81},
      '{"ror",       1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'hC0},
      '{"load81e",   1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81},
      '{"asr",       1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'hC0},
      '{"en0_hold",  1'b0, 3'b010, 8'hFF, 1'b1, 1'b1, 8'hC0},
      '{"mode_hold", 1'b1, 3'b000, 8'hFF, 1'b1, 1'b1, 8'hC0},
      '{"shr_sin1",  1'b1, 3'b011, 8'h00, 1'b1, 1'b0, 8'hE0},
      '{"shl_sin0",  1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 8'hC0}
    };

    reset_n = 1'b0;
    drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);

    // Reset held for two edges.
    step("reset1", RESET_VAL, 1'b0, 1'b0);
    step("reset2", RESET_VAL, 1'b0, 1'b0);

    reset_n = 1'b1;
    drive(1'b1, 3'b001, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0);
    step("load3C", 8'h3C, 1'b0, 1'b0);

    // reset_n low between edges must not disturb q.
    reset_n = 1'b0;
    #3;
    check("sync_reset.q", q, 8'h3C);
    reset_n = 1'b1;

    drive(1'b0, 3'b111, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    step("en0_clear", 8'h3C, 1'b0, 1'b0);
    drive(1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    step("clear", 8'h00, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sin_l,
            vecs[i].sin_r, 1'b0, 4'd0);
      step(vecs[i].name, vecs[i].exp_q, 1'b0, 1'b0);
    end

    // Burst rol x3 with distractions on the inputs while busy.
    drive(1'b1, 3'b001, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
    step("b_load01", 8'h01, 1'b0, 1'b0);
    drive(1'b1, 3'b100, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd3);
    step("b_step1", 8'h02, 1'b1, 1'b0);
    drive(1'b1, 3'b111, 8'h55, 1'b1, 1'b1, 1'b1, 4'd7);
    step("b_step2", 8'h04, 1'b1, 1'b0);
    drive(1'b1, 3'b001, 8'hAA, 1'b1, 1'b1, 1'b0, 4'd2);
    step("b_step3", 8'h08, 1'b0, 1'b1);
    drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    step("b_after", 8'h08, 1'b0, 1'b0);

    // Reset mid-burst aborts and the burst never resumes.
    drive(1'b1, 3'b001, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
    step("r_load01", 8'h01, 1'b0, 1'b0);
    drive(1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5);
    step("r_step1", 8'h02, 1'b1, 1'b0);
    drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    step("r_step2", 8'h04, 1'b1, 1'b0);
    reset_n = 1'b0;
    step("r_reset", RESET_VAL, 1'b0, 1'b0);
    reset_n = 1'b1;
    step("r_idle1", RESET_VAL, 1'b0, 1'b0);
    step("r_idle2", RESET_VAL, 1'b0, 1'b0);

    // burst_len=0: plain single shl via en.
    drive(1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0);
    step("len0_shl", 8'h4A, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    step("len0_after", 8'h4A, 1'b0, 1'b0);

    // start with load mode: ordinary load, no burst.
    drive(1'b1, 3'b001, 8'h3C, 1'b0, 1'b0, 1'b1, 4'd3);
    step("st_load", 8'h3C, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    step("st_load_after", 8'h3C, 1'b0, 1'b0);

    // burst_len=1: one step, done next cycle, busy never set.
    drive(1'b0, 3'b011, 8'h00, 1'b1, 1'b0, 1'b1, 4'd1);
    step("len1_step", 8'h9E, 1'b0, 1'b1);
    // New burst accepted in the done cycle.
    drive(1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2);
    step("bb_step1", 8'h3D, 1'b1, 1'b0);
    drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    step("bb_step2", 8'h7A, 1'b0, 1'b1);
    step("bb_after", 8'h7A, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with Q/Qbar outputs plus hold, load, shift, rotate and clear modes.
- Adds a burst engine that repeats one shift/rotate op for a programmed number of cycles, with busy/done status.
- Used as a general-purpose storage/serialisation element in the sequential blocks of the design.

Parameters:
- WIDTH, 8, register width in bits (must be >= 2).
- RESET_VAL, 0, value loaded into q while reset_n is low.
- CNT_W, 4, width of burst_len and of the internal remaining-step counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- en  input  1  enables single-cycle ops; ignored during a burst.
- mode  input  3  op select: 000 hold, 001 load d, 010 shl, 011 shr, 100 rol, 101 ror, 110 asr, 111 clear.
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial in to bit 0 for shl.
- sin_l  input  1  serial in to MSB for shr.
- start  input  1  request a burst of the shift/rotate op on mode.
- burst_len  input  CNT_W  number of steps in the burst.
- q  output  WIDTH  register contents.
- q_bar  output  WIDTH  ~q, combinational.
- sout_l  output  1  q[WIDTH-1], combinational.
- sout_r  output  1  q[0], combinational.
- busy  output  1  registered; high while burst steps remain.
- done  output  1  registered; one-cycle pulse after the final burst step.

Behaviour:
- Priority per edge: reset_n, then burst in progress, then start, then en/mode.
- Reset (reset_n=0 at an edge): q=RESET_VAL, busy=0, done=0, counter cleared, FSM to IDLE. No asynchronous effect. Any burst in flight is aborted and never resumes.
- Op semantics:
  - shl: {q[W-2:0],sin_r}.
  - shr: {sin_l,q[W-1:1]}.
  - rol: {q[W-2:0],q[W-1]}.
  - ror: {q[0],q[W-1:1]}.
  - asr: {q[W-1],q[W-1:1]}.
  - clear: all zeros, not RESET_VAL.
  - hold: q unchanged.
- IDLE, en=1, no valid start: q updates with the selected op at the edge (1-cycle latency).
- IDLE, en=0, no valid start: q holds.
- Valid start: start=1, mode in 010..110, burst_len!=0; en is don't-care.
  - Start edge: latch mode, perform step 1, rem=burst_len-1.
  - If rem=0: stay IDLE, done=1 next cycle, busy never asserted.
  - Else: go to BURST, busy=1.
- Invalid start: start=1 with mode 000/001/111 or burst_len=0. start is ignored and the normal en/mode path applies.
- BURST state, each edge:
  - Perform the latched op; sin_l/sin_r are sampled live each step.
  - Decrement rem.
  - When the step just taken was the last (rem was 1): busy=0, done=1, go to IDLE.
  - en, mode, d and start are ignored while in BURST.
- done is high for exactly one cycle and deasserts at the next edge.
- A valid start in the cycle done is high is accepted; done still deasserts on schedule.
- Burst timing for N steps: q changes on N consecutive edges; busy high for N-1 cycles; done high in the cycle after the Nth edge.
- burst_len larger than WIDTH is legal: rotates wrap; shl/shr fill with the serial inputs.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5, reset_n=0 for 2 edges -> q=A5, q_bar=5A, busy=0, done=0. reset_n=0 with no clk edge -> q unchanged (synchronous check).
- Load/hold/clear: en=1 mode=001 d=3C -> q=3C after 1 edge. en=0 mode=111 -> q stays 3C. en=1 mode=111 -> q=00.
- Single ops from q=81, one edge each:
  - shl sin_r=1 -> 03.
  - shr sin_l=0 -> 40.
  - rol -> 03.
  - ror -> C0.
  - asr -> C0.
  - sout_l/sout_r track q each cycle.
- Burst: q=01, start=1 mode=100 burst_len=3 -> q=02,04,08 on 3 consecutive edges; busy=1 for 2 cycles; done=1 for one cycle with q=08. Toggling mode/d/en/start during busy has no effect.
- Reset mid-burst: q=01, rol burst_len=5; drop reset_n after 2 steps -> q=A5, busy=0, done=0; no further shifting after reset_n returns high.
- Degenerate starts:
  - start with burst_len=0, en=1 mode=010 -> single shl, busy/done stay 0.
  - start with mode=001 -> plain load.
  - burst_len=1 -> one step, busy stays 0, done pulses once.
